keypad_debounce: RTL and testbench

- Upstream stage of the door-lock FSM (16-bit one-hot keypad input `x`).
- Synchronises the raw 16-line keypad, debounces it, and rejects multi-key presses.
- Emits each accepted key as a single-cycle one-hot code; the code is all-zero otherwise, which is the FSM's "no key" pattern.
- Produces exactly one pulse per physical press, with no auto-repeat.

---
 rtl/keypad_debounce_pkg.sv | 27 ++
 rtl/keypad_sync.sv | 26 ++
 rtl/keypad_debounce.sv | 147 ++++++++++++++
 tb/tb_keypad_debounce.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_debounce_pkg.sv
// Shared keypad definitions: key width, debounce FSM states and popcount classes.
// Also used by the door-lock FSM for its key width.
package keypad_debounce_pkg;

  localparam int KEY_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    WAIT_REL = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } key_class_e;

  // Saturating step used while scanning the lines: NONE -> SINGLE -> MULTI.
  function automatic key_class_e bump_class(input key_class_e cls);
    case (cls)
      NONE:    bump_class = SINGLE;
      default: bump_class = MULTI;
    endcase
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser, one chain per line, for the asynchronous keypad inputs.
module keypad_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_debounce.sv
// Keypad front end: synchronise, debounce, reject multi-key presses and emit
// one single-cycle one-hot pulse per accepted press.
module keypad_debounce #(
  parameter int KEY_W           = keypad_debounce_pkg::KEY_W,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_raw,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             multi_err
);

  import keypad_debounce_pkg::*;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  logic [KEY_W-1:0] key_s;
  key_class_e       key_cls;

  state_e           state_q, state_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_valid_q, key_valid_d;
  logic             multi_err_q, multi_err_d;

  keypad_sync #(
    .W (KEY_W)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (key_s)
  );

  always_comb begin
    key_cls = NONE;
    for (int i = 0; i < KEY_W; i++) begin
      if (key_s[i]) key_cls = bump_class(key_cls);
    end
  end

  assign cnt_inc = cnt_q + CNT_ONE;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_out_d   = '0;
    key_valid_d = 1'b0;
    multi_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        case (key_cls)
          SINGLE: begin
            cand_d  = key_s;
            cnt_d   = CNT_ONE;
            state_d = COUNT;
          end
          MULTI: begin
            multi_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT_REL;
          end
          default: ;
        endcase
      end

      COUNT: begin
        case (key_cls)
          NONE: begin
            cnt_d   = '0;
            state_d = IDLE;
          end
          // A MULTI sample never equals cand, so it wins over a completing count.
          MULTI: begin
            multi_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT_REL;
          end
          default: begin
            if (key_s != cand_q) begin
              cand_d = key_s;
              cnt_d  = CNT_ONE;
            end else if (cnt_inc == CNT_DONE) begin
              key_out_d   = cand_q;
              key_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = WAIT_REL;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end

      WAIT_REL: begin
        if (key_cls == NONE) begin
          if (cnt_inc == CNT_DONE) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign multi_err = multi_err_q;

endmodule

// File: tb/tb_keypad_debounce.sv
// Self-checking bench for keypad_debounce: scenario tasks push expected pulses
// into a scoreboard that a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_keypad_debounce;
  import keypad_debounce_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] key_raw;
  logic [15:0] key_out;
  logic        key_valid;
  logic        multi_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] key;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  keypad_debounce #(
    .KEY_W           (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .key_out   (key_out),
    .key_valid (key_valid),
    .multi_err (multi_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    n_checks++;
    if (key_valid === 1'b1 && multi_err === 1'b1) begin
      n_errors++;
      $display("FAIL both_pulses: cyc=%0d key_valid=%0b multi_err=%0b, required not both high", cyc, key_valid, multi_err);
    end
    n_checks++;
    if (key_valid !== 1'b1 && key_out !== 16'h0000) begin
      n_errors++;
      $display("FAIL idle_key_out: cyc=%0d key_out=%h, required 0000", cyc, key_out);
    end
    if (key_valid === 1'b1 || multi_err === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_pulse: cyc=%0d key_valid=%0b multi_err=%0b key_out=%h, required no pulse",
                 cyc, key_valid, multi_err, key_out);
      end else begin
        mon_e = sb_q.pop_front();
        if (key_valid !== !mon_e.is_err || multi_err !== mon_e.is_err ||
            key_out !== (mon_e.is_err ? 16'h0000 : mon_e.key) || cyc != mon_e.cyc) begin
          n_errors++;
          $display("FAIL sb_pulse: got valid=%0b err=%0b key=%h cyc=%0d, required valid=%0b err=%0b key=%h cyc=%0d",
                   key_valid, multi_err, key_out, cyc, !mon_e.is_err, mon_e.is_err,
                   mon_e.is_err ? 16'h0000 : mon_e.key, mon_e.cyc);
        end
      end
    end
  end

  task automatic hold(input logic [15:0] v, input int n);
    key_raw = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input bit is_err, input logic [15:0] key, input int at_cyc);
    exp_t e;
    e.is_err = is_err;
    e.key    = key;
    e.cyc    = at_cyc;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    key_raw = '0;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (key_out !== 16'h0000 || key_valid !== 1'b0 || multi_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: key_out=%h valid=%0b err=%0b, required 0000/0/0", key_out, key_valid, multi_err);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dut.state_q, IDLE);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean_press();
    int c0;
    c0 = cyc;
    push_exp(1'b0, 16'h0004, c0 + 6);
    hold(16'h0004, 10);
    hold(16'h0000, 5);
    n_checks++;
    if (dut.state_q !== WAIT_REL) begin
      n_errors++;
      $display("FAIL clean_wait_rel: state=%0d, required %0d", dut.state_q, WAIT_REL);
    end
    hold(16'h0000, 1);
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_errors++;
      $display("FAIL clean_back_idle: state=%0d, required %0d", dut.state_q, IDLE);
    end
    hold(16'h0000, 2);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL clean_drained: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_bounce();
    hold(16'h0004, 2);
    hold(16'h0000, 1);
    hold(16'h0004, 2);
    hold(16'h0000, 10);
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_errors++;
      $display("FAIL bounce_idle: state=%0d, required %0d", dut.state_q, IDLE);
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL bounce_drained: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_multi_key();
    int c0;
    int c1;
    c0 = cyc;
    push_exp(1'b1, 16'h0000, c0 + 3);
    hold(16'h0011, 8);
    n_checks++;
    if (dut.state_q !== WAIT_REL) begin
      n_errors++;
      $display("FAIL multi_wait_rel: state=%0d, required %0d", dut.state_q, WAIT_REL);
    end
    hold(16'h0000, 6);
    c1 = cyc;
    push_exp(1'b0, 16'h8000, c1 + 6);
    hold(16'h8000, 10);
    hold(16'h0000, 8);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL multi_drained: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_hold_repress();
    int c0;
    int c2;
    c0 = cyc;
    push_exp(1'b0, 16'h0001, c0 + 6);
    hold(16'h0001, 100);
    hold(16'h0000, 2);
    hold(16'h0001, 10);
    hold(16'h0000, 6);
    c2 = cyc;
    push_exp(1'b0, 16'h0001, c2 + 6);
    hold(16'h0001, 10);
    hold(16'h0000, 8);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL repress_drained: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_key_change();
    int c0;
    c0 = cyc;
    push_exp(1'b0, 16'h0002, c0 + 8);
    hold(16'h0001, 2);
    hold(16'h0002, 12);
    hold(16'h0000, 8);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL change_drained: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    int c3;
    c0 = cyc;
    hold(16'h0004, 5);
    @(posedge clk);
    #1;
    n_checks++;
    if (key_valid !== 1'b1 || key_out !== 16'h0004 || cyc != c0 + 6) begin
      n_errors++;
      $display("FAIL midrst_accept: valid=%0b key=%h cyc=%0d, required 1/0004/%0d", key_valid, key_out, cyc, c0 + 6);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (key_valid !== 1'b0 || key_out !== 16'h0000 || multi_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_drop: valid=%0b key=%h err=%0b, required 0/0000/0", key_valid, key_out, multi_err);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_errors++;
      $display("FAIL midrst_state: state=%0d, required %0d", dut.state_q, IDLE);
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    c3 = cyc;
    push_exp(1'b0, 16'h0004, c3 + 6);
    hold(16'h0004, 10);
    hold(16'h0000, 8);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL midrst_drained: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: time=%0t, required finish before 100000", $time);
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi_key();
    test_hold_repress();
    test_key_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
